// File: rtl/arith_divider.sv
// 4-bit unsigned restoring divider: four iterations per quotient, direct post on divide-by-zero.
// Optional remainder output register is enabled by defining ARITH_DIVIDER_REMAINDER_EN.
module arith_divider (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [3:0] x,
   input  logic [3:0] y,
   output logic [3:0] q,
   output logic [3:0] r,
   output logic       busy,
   output logic       done,
   output logic       dz
);

   localparam int DATA_W = 4;

   // ZDIV spaces the divide-by-zero result one cycle after acceptance so that done
   // appears after the following edge, with busy never asserted on that path.
   typedef enum logic [1:0] {IDLE, RUN, ZDIV, DONE} state_t;

   state_t              state_q;
   logic [DATA_W-1:0]   dvd_q;
   logic [DATA_W-1:0]   dvs_q;
   logic [DATA_W-1:0]   rem_q;
   logic [DATA_W-1:0]   q_q;
   logic [1:0]          cnt_q;
   logic                busy_q;
   logic                done_q;
   logic                dz_q;
`ifdef ARITH_DIVIDER_REMAINDER_EN
   logic [DATA_W-1:0]   r_q;
`endif

   logic [DATA_W:0]     partial_d;
   logic [DATA_W:0]     trial_d;
   logic                qbit_d;
   logic [DATA_W-1:0]   rem_d;
   logic [DATA_W-1:0]   quo_d;

   // dvd_q shifts dividend bits out of the top and quotient bits in at the bottom.
   always_comb begin
      partial_d = {rem_q, dvd_q[DATA_W-1]};
      trial_d   = partial_d - {1'b0, dvs_q};
      qbit_d    = ~trial_d[DATA_W];
      rem_d     = qbit_d ? trial_d[DATA_W-1:0] : partial_d[DATA_W-1:0];
      quo_d     = {dvd_q[DATA_W-2:0], qbit_d};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         dvd_q   <= '0;
         dvs_q   <= '0;
         rem_q   <= '0;
         q_q     <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
`ifdef ARITH_DIVIDER_REMAINDER_EN
         r_q     <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  dvd_q <= x;
                  dvs_q <= y;
                  rem_q <= '0;
                  cnt_q <= '0;
                  dz_q  <= 1'b0;
                  if (y == '0) begin
                     state_q <= ZDIV;
                  end else begin
                     state_q <= RUN;
                     busy_q  <= 1'b1;
                  end
               end
            end
            RUN: begin
               dvd_q <= quo_d;
               rem_q <= rem_d;
               cnt_q <= cnt_q + 2'd1;
               if (cnt_q == 2'd3) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  q_q     <= quo_d;
`ifdef ARITH_DIVIDER_REMAINDER_EN
                  r_q     <= rem_d;
`endif
               end
            end
            ZDIV: begin
               state_q <= DONE;
               done_q  <= 1'b1;
               dz_q    <= 1'b1;
               q_q     <= '1;
`ifdef ARITH_DIVIDER_REMAINDER_EN
               r_q     <= dvd_q;
`endif
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign q    = q_q;
   assign busy = busy_q;
   assign done = done_q;
   assign dz   = dz_q;
`ifdef ARITH_DIVIDER_REMAINDER_EN
   assign r    = r_q;
`else
   assign r    = '0;
`endif

endmodule

// File: doc/arith_divider.md
ARITH_DIVIDER -- requirements
Module: arith_divider

Interface
REQ-001 SHALL have: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have: start  input  1  request a division; sampled on rising clk.
REQ-004 SHALL have: x  input  4  dividend, unsigned.
REQ-005 SHALL have: y  input  4  divisor, unsigned.
REQ-006 SHALL have: q  output  4  quotient, registered.
REQ-007 SHALL have: r  output  4  remainder, registered.
REQ-008 SHALL have: busy  output  1  high while iterating.
REQ-009 SHALL have: done  output  1  one-cycle pulse; results valid.
REQ-010 SHALL have: dz  output  1  divide-by-zero flag for the current result.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DONE.
REQ-012 IDLE: start=1 at an edge SHALL capture x and y into internal registers, clear dz, and enter RUN; when y=0, enter DONE instead.
REQ-013 RUN SHALL perform one restoring step per cycle, MSB first: partial = {rem[3:0], next dividend bit}; trial = partial - divisor (5-bit); trial non-negative -> quotient bit 1, rem = trial; otherwise quotient bit 0, rem = partial.
REQ-014 RUN SHALL last exactly 4 cycles, counted by a 2-bit step counter, then enter DONE.
REQ-015 Latency: start accepted at edge k -> done high after edge k+4, low after edge k+5.
REQ-016 Divide-by-zero: start accepted at edge k with y=0 -> after edge k+1, done=1, dz=1, q=4'hF, r=x.
REQ-017 DONE SHALL last one cycle, assert done, then return to IDLE unconditionally.
REQ-018 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE.
REQ-019 start in RUN or DONE SHALL be ignored; no queuing. The operands captured at acceptance SHALL be unaffected by later changes to x or y.
REQ-020 q, r, dz SHALL update only on entry to DONE and hold until the next DONE entry.
REQ-021 Results SHALL satisfy x = q*y + r with r < y for all y != 0.

Reset
REQ-022 rst_n=0 SHALL immediately force state IDLE and q=0, r=0, busy=0, done=0, dz=0, and clear the internal registers, independent of clk.
REQ-023 Reset asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow reset release.
REQ-024 The first edge after release with start=1 SHALL be accepted normally.

Configuration
REQ-025 Macro ARITH_DIVIDER_REMAINDER_EN defined: r SHALL carry the final remainder as specified.
REQ-026 Macro ARITH_DIVIDER_REMAINDER_EN undefined: the remainder output register SHALL be omitted and r SHALL be constant 0. The internal remainder logic used for quotient computation, all other behaviour and all latencies SHALL be unchanged.

Verification
REQ-027 x=13, y=3, start pulse -> done after 4 edges, q=4, r=1, dz=0, busy high for 4 cycles.
REQ-028 x=15, y=1 -> q=15, r=0. x=2, y=7 -> q=0, r=2. Also an exhaustive 256-pair sweep against REQ-021.
REQ-029 x=5, y=0 -> done after 1 edge, dz=1, q=4'hF, r=5, busy never high.
REQ-030 Start 9/2; 2 cycles later, start 15/15 with changed x/y -> single done, q=4, r=1; the second request is dropped.
REQ-031 rst_n low during the 3rd RUN cycle -> all outputs 0 immediately, no done. After release, 6/3 -> q=2, r=0.
REQ-032 Rebuild without ARITH_DIVIDER_REMAINDER_EN, 13/3 -> q=4, r=0, same latency.
